// File: rtl/qenc_cnt_pkg.sv
// Shared constants and Gray-step decode for the quadrature pulse counter.
// Field layout of the read word and the 4x decode table live here.
package qenc_cnt_pkg;

   localparam int CNT_W   = 15;
   localparam int ERR_BIT = 15;
   localparam int CH1_LSB = 16;

   // Forward (A-leads) order of {A,B}; position in this table is the phase index.
   localparam logic [1:0] GRAY_SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_INC  = 2'd1,
      STEP_DEC  = 2'd2,
      STEP_ERR  = 2'd3
   } step_e;

   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      logic [1:0] pos;
      pos = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (GRAY_SEQ[i] == ab) pos = 2'(i);
      end
      return pos;
   endfunction

   // Phase distance mod 4: +1 forward, -1 (3) reverse, 2 means both bits flipped.
   function automatic step_e decode_step(input logic [1:0] old_ab, input logic [1:0] new_ab);
      logic [1:0] diff;
      step_e      step;
      diff = gray_pos(new_ab) - gray_pos(old_ab);
      case (diff)
         2'd1:    step = STEP_INC;
         2'd3:    step = STEP_DEC;
         2'd2:    step = STEP_ERR;
         default: step = STEP_NONE;
      endcase
      return step;
   endfunction

endpackage

// File: rtl/qenc_chan.sv
// One quadrature channel: 2-FF synchronizer, glitch filter, priming,
// 4x decoder, 15-bit wrapping counter and sticky illegal-transition flag.
module qenc_chan
   import qenc_cnt_pkg::*;
#(
   parameter int FILT = 4,
   parameter int FW   = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [1:0]       q_i,
   input  logic             wr_lo_i,
   input  logic             wr_hi_i,
   input  logic [15:0]      wdat_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             err_o
);

   localparam logic [FW-1:0] FLAST = FW'(FILT - 1);

   logic [1:0]       s1_q, s2_q;
   logic [1:0]       cand_q, cand_d;
   logic [1:0]       acc_q, acc_d;
   logic [FW-1:0]    fcnt_q, fcnt_d;
   logic             primed_q, primed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   step_e            evt;

   // NOTE: every register here uses non-blocking assignment so that s2_q samples
   // the pre-edge s1_q; blocking would collapse the synchronizer to one stage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q     <= 2'b00;
         s2_q     <= 2'b00;
         cand_q   <= 2'b00;
         acc_q    <= 2'b00;
         fcnt_q   <= '0;
         primed_q <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         s1_q     <= q_i;
         s2_q     <= s1_q;
         cand_q   <= cand_d;
         acc_q    <= acc_d;
         fcnt_q   <= fcnt_d;
         primed_q <= primed_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // NOTE: each comb output gets a hold-value default first, so no path infers a latch.
   always_comb begin
      cand_d   = cand_q;
      acc_d    = acc_q;
      fcnt_d   = fcnt_q;
      primed_d = primed_q;
      evt      = STEP_NONE;
      if (s2_q != cand_q) begin
         cand_d = s2_q;
         fcnt_d = '0;
      end else if (fcnt_q < FLAST) begin
         fcnt_d = fcnt_q + FW'(1);
      end else if (!primed_q) begin
         // First stable value after reset is the reference point, never a step.
         primed_d = 1'b1;
         acc_d    = cand_q;
      end else if (cand_q != acc_q) begin
         acc_d = cand_q;
         evt   = decode_step(acc_q, cand_q);
      end
   end

   // A bus write to either byte takes precedence and drops that cycle's count step.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (wr_lo_i || wr_hi_i) begin
         if (wr_lo_i) cnt_d[7:0]       = wdat_i[7:0];
         if (wr_hi_i) cnt_d[CNT_W-1:8] = wdat_i[CNT_W-1:8];
      end else if (evt == STEP_INC) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (evt == STEP_DEC) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      if (evt == STEP_ERR) err_d = 1'b1;
      if (wr_hi_i && wdat_i[15]) err_d = 1'b0;
   end

   assign cnt_o = cnt_q;
   assign err_o = err_q;

endmodule

// File: rtl/qenc_cnt.sv
// Dual-channel quadrature pulse counter at register slot 7: splits write
// bytes per channel and concatenates the read word.
module qenc_cnt
   import qenc_cnt_pkg::*;
#(
   parameter int FILT = 4,
   parameter int FW   = 8
) (
   input  logic        wb_clk,
   input  logic        wb_rst_n,
   input  logic        we,
   input  logic [3:0]  sel,
   input  logic [31:0] dat,
   output logic [31:0] rdt,
   input  logic [1:0]  qa,
   input  logic [1:0]  qb
);

   logic [CNT_W-1:0] cnt0, cnt1;
   logic             err0, err1;

   qenc_chan #(.FILT(FILT), .FW(FW)) u_chan0 (
      .clk_i   (wb_clk),
      .rst_ni  (wb_rst_n),
      .q_i     ({qa[0], qb[0]}),
      .wr_lo_i (we & sel[0]),
      .wr_hi_i (we & sel[1]),
      .wdat_i  (dat[15:0]),
      .cnt_o   (cnt0),
      .err_o   (err0)
   );

   qenc_chan #(.FILT(FILT), .FW(FW)) u_chan1 (
      .clk_i   (wb_clk),
      .rst_ni  (wb_rst_n),
      .q_i     ({qa[1], qb[1]}),
      .wr_lo_i (we & sel[2]),
      .wr_hi_i (we & sel[3]),
      .wdat_i  (dat[31:16]),
      .cnt_o   (cnt1),
      .err_o   (err1)
   );

   always_comb begin
      rdt                          = '0;
      rdt[CNT_W-1:0]               = cnt0;
      rdt[ERR_BIT]                 = err0;
      rdt[CH1_LSB +: CNT_W]        = cnt1;
      rdt[CH1_LSB + ERR_BIT]       = err1;
   end

endmodule
